// File: rtl/mem_copy_engine.sv
// mem_copy_engine
//   DMA-style helper that drives two word-memory masters: a read-only master
//   (rd_*) and a write-only master (wr_*). It copies a block of 32-bit words
//   (mode 0) or fills a block with a pattern (mode 1) at one word per cycle.
//   It then reports completion with a one-cycle done pulse.
//
// Ports
//   CLK, RST_N           clock, asynchronous active-low reset
//   start_i              start pulse, only looked at while idle
//   mode_i               0 = copy, 1 = fill
//   src_addr_i           source byte address (copy only)
//   dst_addr_i           destination byte address
//   len_i                transfer length in words
//   pattern_i            fill word
//   abort_i              stop issuing new requests (only honoured in RUN)
//   busy_o               high from start acceptance until the done pulse
//   done_o               one-cycle completion pulse
//   err_o, aborted_o     status, valid with done_o
//   words_o              words written, valid with done_o, held until next start
//   rd_*                 read master request outputs and response inputs
//   wr_*                 write master request outputs and response inputs
module mem_copy_engine #(
    parameter int LenWidth = 16
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                start_i,
    input  logic                mode_i,
    input  logic [31:0]         src_addr_i,
    input  logic [31:0]         dst_addr_i,
    input  logic [LenWidth-1:0] len_i,
    input  logic [31:0]         pattern_i,
    input  logic                abort_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic                aborted_o,
    output logic [LenWidth-1:0] words_o,
    output logic                rd_req_o,
    output logic                rd_we_o,
    output logic [3:0]          rd_be_o,
    output logic [31:0]         rd_addr_o,
    output logic [31:0]         rd_wdata_o,
    input  logic                rd_rvalid_i,
    input  logic [31:0]         rd_rdata_i,
    output logic                wr_req_o,
    output logic                wr_we_o,
    output logic [3:0]          wr_be_o,
    output logic [31:0]         wr_addr_o,
    output logic [31:0]         wr_wdata_o,
    input  logic                wr_rvalid_i,
    input  logic [31:0]         wr_rdata_i
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [LenWidth-1:0] LenOne = LenWidth'(1);

    state_t              state;
    logic                mode_q;
    logic [LenWidth-1:0] len_q;
    logic [LenWidth-1:0] rd_cnt;
    logic [LenWidth-1:0] wr_cnt;
    logic [LenWidth-1:0] resp_cnt;
    logic [31:0]         wr_ptr;
    logic [31:0]         pattern_q;

    logic                cfg_err;
    logic [LenWidth-1:0] resp_next;
    logic                drain_done;
    logic                unused_wr_rdata;

    // The read master never writes.
    assign rd_we_o    = 1'b0;
    assign rd_be_o    = 4'hF;
    assign rd_wdata_o = '0;

    // Write responses carry no data of interest.
    assign unused_wr_rdata = ^wr_rdata_i;

    // Source alignment only matters when a source is actually read.
    assign cfg_err = (len_i == '0)
                   || (!mode_i && (src_addr_i[1:0] != 2'b00))
                   || (dst_addr_i[1:0] != 2'b00);

    assign resp_next = resp_cnt + (wr_rvalid_i ? LenOne : '0);

    // In copy mode every issued read must have turned into a write
    // (wr_cnt == rd_cnt) before the write responses can be considered final.
    assign drain_done = (resp_next == wr_cnt) && (mode_q || (wr_cnt == rd_cnt));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            mode_q     <= 1'b0;
            len_q      <= '0;
            rd_cnt     <= '0;
            wr_cnt     <= '0;
            resp_cnt   <= '0;
            wr_ptr     <= '0;
            pattern_q  <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            aborted_o  <= 1'b0;
            words_o    <= '0;
            rd_req_o   <= 1'b0;
            rd_addr_o  <= '0;
            wr_req_o   <= 1'b0;
            wr_we_o    <= 1'b0;
            wr_be_o    <= 4'h0;
            wr_addr_o  <= '0;
            wr_wdata_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        mode_q    <= mode_i;
                        len_q     <= len_i;
                        pattern_q <= pattern_i;
                        words_o   <= '0;
                        err_o     <= 1'b0;
                        aborted_o <= 1'b0;
                        rd_cnt    <= '0;
                        wr_cnt    <= '0;
                        resp_cnt  <= '0;
                        if (cfg_err) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                            err_o  <= 1'b1;
                        end else begin
                            state  <= RUN;
                            busy_o <= 1'b1;
                            // The first request goes out in the cycle right after start.
                            if (mode_i) begin
                                wr_req_o   <= 1'b1;
                                wr_we_o    <= 1'b1;
                                wr_be_o    <= 4'hF;
                                wr_addr_o  <= dst_addr_i;
                                wr_wdata_o <= pattern_i;
                                wr_ptr     <= dst_addr_i + 32'd4;
                                wr_cnt     <= LenOne;
                            end else begin
                                rd_req_o  <= 1'b1;
                                rd_addr_o <= src_addr_i;
                                rd_cnt    <= LenOne;
                                wr_ptr    <= dst_addr_i;
                            end
                        end
                    end
                end

                RUN, DRAIN: begin
                    resp_cnt <= resp_next;

                    // Copy writes follow read data as it returns, in RUN or DRAIN;
                    // fill writes are only generated while running and not aborted.
                    if (!mode_q && rd_rvalid_i) begin
                        wr_req_o   <= 1'b1;
                        wr_we_o    <= 1'b1;
                        wr_be_o    <= 4'hF;
                        wr_addr_o  <= wr_ptr;
                        wr_wdata_o <= rd_rdata_i;
                        wr_ptr     <= wr_ptr + 32'd4;
                        wr_cnt     <= wr_cnt + LenOne;
                    end else if (mode_q && (state == RUN) && !abort_i && (wr_cnt != len_q)) begin
                        wr_req_o   <= 1'b1;
                        wr_we_o    <= 1'b1;
                        wr_be_o    <= 4'hF;
                        wr_addr_o  <= wr_ptr;
                        wr_wdata_o <= pattern_q;
                        wr_ptr     <= wr_ptr + 32'd4;
                        wr_cnt     <= wr_cnt + LenOne;
                    end else begin
                        wr_req_o <= 1'b0;
                        wr_we_o  <= 1'b0;
                        wr_be_o  <= 4'h0;
                    end

                    if (state == RUN) begin
                        if (!mode_q && !abort_i && (rd_cnt != len_q)) begin
                            rd_req_o  <= 1'b1;
                            rd_addr_o <= rd_addr_o + 32'd4;
                            rd_cnt    <= rd_cnt + LenOne;
                        end else begin
                            rd_req_o <= 1'b0;
                        end
                        if (abort_i || (mode_q ? (wr_cnt == len_q) : (rd_cnt == len_q))) begin
                            state <= DRAIN;
                            if (abort_i) begin
                                aborted_o <= 1'b1;
                            end
                        end
                    end else if (drain_done) begin
                        state   <= DONE;
                        done_o  <= 1'b1;
                        busy_o  <= 1'b0;
                        words_o <= wr_cnt;
                    end
                end

                DONE: begin
                    done_o <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine
//   Directed bench for mem_copy_engine. A small dual-port word memory model
//   answers both masters one cycle after each request. Every scenario task
//   drives its own stimulus and compares against hand-computed values.
module tb_mem_copy_engine;

    localparam int LenWidth = 16;

    logic                CLK = 1'b0;
    logic                RST_N;
    logic                start_i;
    logic                mode_i;
    logic [31:0]         src_addr_i;
    logic [31:0]         dst_addr_i;
    logic [LenWidth-1:0] len_i;
    logic [31:0]         pattern_i;
    logic                abort_i;
    logic                busy_o;
    logic                done_o;
    logic                err_o;
    logic                aborted_o;
    logic [LenWidth-1:0] words_o;
    logic                rd_req_o;
    logic                rd_we_o;
    logic [3:0]          rd_be_o;
    logic [31:0]         rd_addr_o;
    logic [31:0]         rd_wdata_o;
    logic                rd_rvalid_i;
    logic [31:0]         rd_rdata_i;
    logic                wr_req_o;
    logic                wr_we_o;
    logic [3:0]          wr_be_o;
    logic [31:0]         wr_addr_o;
    logic [31:0]         wr_wdata_o;
    logic                wr_rvalid_i;
    logic [31:0]         wr_rdata_i;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int t0           = 0;
    int rd_base      = 0;
    int wr_base      = 0;
    int done_count   = 0;

    logic [31:0] rd_log_addr[$];
    int          rd_log_cyc[$];
    logic [31:0] wr_log_addr[$];
    logic [31:0] wr_log_data[$];
    int          wr_log_cyc[$];

    logic [31:0] mem [0:1023];
    logic        pl_en   = 1'b0;
    logic [9:0]  pl_idx  = '0;
    logic [31:0] pl_data = '0;

    mem_copy_engine #(.LenWidth(LenWidth)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .start_i(start_i), .mode_i(mode_i),
        .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i),
        .len_i(len_i), .pattern_i(pattern_i), .abort_i(abort_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .aborted_o(aborted_o), .words_o(words_o),
        .rd_req_o(rd_req_o), .rd_we_o(rd_we_o), .rd_be_o(rd_be_o),
        .rd_addr_o(rd_addr_o), .rd_wdata_o(rd_wdata_o),
        .rd_rvalid_i(rd_rvalid_i), .rd_rdata_i(rd_rdata_i),
        .wr_req_o(wr_req_o), .wr_we_o(wr_we_o), .wr_be_o(wr_be_o),
        .wr_addr_o(wr_addr_o), .wr_wdata_o(wr_wdata_o),
        .wr_rvalid_i(wr_rvalid_i), .wr_rdata_i(wr_rdata_i)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Dual-port memory: response one cycle after request, writes land at the edge.
    always @(posedge CLK) begin
        rd_rvalid_i <= RST_N && rd_req_o;
        rd_rdata_i  <= mem[rd_addr_o[11:2]];
        wr_rvalid_i <= RST_N && wr_req_o;
        wr_rdata_i  <= 32'h0;
        if (pl_en) begin
            mem[pl_idx] <= pl_data;
        end else if (wr_req_o && wr_we_o && (wr_be_o == 4'hF)) begin
            mem[wr_addr_o[11:2]] <= wr_wdata_o;
        end
    end

    // Request/done recorder, cycles relative to the most recent start.
    always @(negedge CLK) begin
        if (rd_req_o) begin
            rd_log_addr.push_back(rd_addr_o);
            rd_log_cyc.push_back(cyc - t0);
        end
        if (wr_req_o) begin
            wr_log_addr.push_back(wr_addr_o);
            wr_log_data.push_back(wr_wdata_o);
            wr_log_cyc.push_back(cyc - t0);
        end
        if (done_o) done_count <= done_count + 1;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic preload(input int idx, input logic [31:0] data);
        @(negedge CLK);
        pl_en   = 1'b1;
        pl_idx  = 10'(idx);
        pl_data = data;
        @(negedge CLK);
        pl_en   = 1'b0;
    endtask

    // Drives a start pulse in the current cycle (cycle 0) and moves to cycle 1.
    task automatic do_start(input logic mode, input logic [31:0] src, input logic [31:0] dst,
                            input logic [LenWidth-1:0] len, input logic [31:0] pat);
        @(negedge CLK);
        t0         = cyc;
        rd_base    = rd_log_addr.size();
        wr_base    = wr_log_addr.size();
        mode_i     = mode;
        src_addr_i = src;
        dst_addr_i = dst;
        len_i      = len;
        pattern_i  = pat;
        start_i    = 1'b1;
        @(negedge CLK);
        start_i    = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit found, output int dcyc, output bit derr,
                             output bit dab, output logic [LenWidth-1:0] dwords, output bit dbusy);
        found = 0; dcyc = -1; derr = 0; dab = 0; dwords = '0; dbusy = 0;
        for (int i = 0; i < budget; i++) begin
            if (done_o) begin
                found  = 1;
                dcyc   = cyc - t0;
                derr   = err_o;
                dab    = aborted_o;
                dwords = words_o;
                dbusy  = busy_o;
                break;
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        tests_run++;
        if ({busy_o, done_o, err_o, aborted_o, rd_req_o, wr_req_o, wr_we_o} !== 7'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: got %b, expected 0000000",
                     {busy_o, done_o, err_o, aborted_o, rd_req_o, wr_req_o, wr_we_o});
        end
        tests_run++;
        if (words_o !== '0 || wr_be_o !== 4'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_words_be: got words=%0d be=%h, expected 0 and 0", words_o, wr_be_o);
        end
        tests_run++;
        if (rd_addr_o !== 32'h0 || wr_addr_o !== 32'h0 || wr_wdata_o !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_addr: got rd=%h wr=%h wd=%h, expected all 0", rd_addr_o, wr_addr_o, wr_wdata_o);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_copy();
        logic [31:0] vals [4] = '{32'h1111_00A0, 32'h2222_00A1, 32'h3333_00A2, 32'h4444_00A3};
        bit found, derr, dab, dbusy; int dcyc; logic [LenWidth-1:0] dwords;
        for (int i = 0; i < 4; i++) preload(i, vals[i]);
        do_start(1'b0, 32'h0, 32'h100, 16'd4, 32'h0);
        tests_run++;
        if (busy_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL copy_busy_c1: got %b, expected 1", busy_o);
        end
        wait_done(40, found, dcyc, derr, dab, dwords, dbusy);
        tests_run++;
        if (!found || dcyc != 8) begin
            tests_failed++;
            $display("[TB] FAIL copy_done_cycle: got %0d (found=%0d), expected 8", dcyc, found);
        end
        tests_run++;
        if (dwords !== 16'd4 || derr || dab || dbusy) begin
            tests_failed++;
            $display("[TB] FAIL copy_status: got words=%0d err=%0d ab=%0d busy=%0d, expected 4 0 0 0",
                     dwords, derr, dab, dbusy);
        end
        tests_run++;
        if (rd_log_addr.size() - rd_base != 4 || wr_log_addr.size() - wr_base != 4) begin
            tests_failed++;
            $display("[TB] FAIL copy_req_count: got rd=%0d wr=%0d, expected 4 4",
                     rd_log_addr.size() - rd_base, wr_log_addr.size() - wr_base);
        end
        for (int i = 0; i < 4 && rd_base + i < rd_log_addr.size(); i++) begin
            tests_run++;
            if (rd_log_addr[rd_base+i] !== 32'(4*i) || rd_log_cyc[rd_base+i] != 1 + i) begin
                tests_failed++;
                $display("[TB] FAIL copy_read%0d: got addr=%h cyc=%0d, expected %h %0d",
                         i, rd_log_addr[rd_base+i], rd_log_cyc[rd_base+i], 4*i, 1 + i);
            end
        end
        for (int i = 0; i < 4 && wr_base + i < wr_log_addr.size(); i++) begin
            tests_run++;
            if (wr_log_addr[wr_base+i] !== 32'h100 + 32'(4*i) || wr_log_data[wr_base+i] !== vals[i]
                || wr_log_cyc[wr_base+i] != 3 + i) begin
                tests_failed++;
                $display("[TB] FAIL copy_write%0d: got addr=%h data=%h cyc=%0d, expected %h %h %0d",
                         i, wr_log_addr[wr_base+i], wr_log_data[wr_base+i], wr_log_cyc[wr_base+i],
                         32'h100 + 32'(4*i), vals[i], 3 + i);
            end
        end
        @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (mem[64+i] !== vals[i]) begin
                tests_failed++;
                $display("[TB] FAIL copy_mem%0d: got %h, expected %h", i, mem[64+i], vals[i]);
            end
        end
    endtask

    task automatic test_fill();
        bit found, derr, dab, dbusy; int dcyc; logic [LenWidth-1:0] dwords;
        do_start(1'b1, 32'h0, 32'h40, 16'd3, 32'hDEAD_BEEF);
        wait_done(40, found, dcyc, derr, dab, dwords, dbusy);
        tests_run++;
        if (!found || dcyc != 5 || dwords !== 16'd3 || derr) begin
            tests_failed++;
            $display("[TB] FAIL fill_done: got cyc=%0d found=%0d words=%0d err=%0d, expected 5 1 3 0",
                     dcyc, found, dwords, derr);
        end
        tests_run++;
        if (rd_log_addr.size() != rd_base || wr_log_addr.size() - wr_base != 3) begin
            tests_failed++;
            $display("[TB] FAIL fill_req_count: got rd=%0d wr=%0d, expected 0 3",
                     rd_log_addr.size() - rd_base, wr_log_addr.size() - wr_base);
        end
        for (int i = 0; i < 3 && wr_base + i < wr_log_addr.size(); i++) begin
            tests_run++;
            if (wr_log_addr[wr_base+i] !== 32'h40 + 32'(4*i) || wr_log_data[wr_base+i] !== 32'hDEAD_BEEF
                || wr_log_cyc[wr_base+i] != 1 + i) begin
                tests_failed++;
                $display("[TB] FAIL fill_write%0d: got addr=%h data=%h cyc=%0d, expected %h deadbeef %0d",
                         i, wr_log_addr[wr_base+i], wr_log_data[wr_base+i], wr_log_cyc[wr_base+i],
                         32'h40 + 32'(4*i), 1 + i);
            end
        end
        @(negedge CLK);
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (mem[16+i] !== 32'hDEAD_BEEF) begin
                tests_failed++;
                $display("[TB] FAIL fill_mem%0d: got %h, expected deadbeef", i, mem[16+i]);
            end
        end
    endtask

    task automatic test_errors();
        bit found, derr, dab, dbusy; int dcyc; logic [LenWidth-1:0] dwords;
        logic [31:0] srcs [3] = '{32'h0, 32'h0, 32'h1};
        logic [31:0] dsts [3] = '{32'h200, 32'h102, 32'h200};
        logic [LenWidth-1:0] lens [3] = '{16'd0, 16'd4, 16'd4};
        for (int k = 0; k < 3; k++) begin
            do_start(1'b0, srcs[k], dsts[k], lens[k], 32'h0);
            wait_done(10, found, dcyc, derr, dab, dwords, dbusy);
            tests_run++;
            if (!found || dcyc != 1 || !derr || dwords !== '0 || dbusy) begin
                tests_failed++;
                $display("[TB] FAIL err_case%0d: got cyc=%0d found=%0d err=%0d words=%0d busy=%0d, expected 1 1 1 0 0",
                         k, dcyc, found, derr, dwords, dbusy);
            end
            repeat (4) @(negedge CLK);
            tests_run++;
            if (rd_log_addr.size() != rd_base || wr_log_addr.size() != wr_base) begin
                tests_failed++;
                $display("[TB] FAIL err_case%0d_reqs: got rd=%0d wr=%0d, expected 0 0",
                         k, rd_log_addr.size() - rd_base, wr_log_addr.size() - wr_base);
            end
        end
        // A misaligned source does not matter in fill mode.
        do_start(1'b1, 32'h3, 32'h80, 16'd1, 32'h0BAD_F00D);
        wait_done(20, found, dcyc, derr, dab, dwords, dbusy);
        tests_run++;
        if (!found || dcyc != 3 || derr || dwords !== 16'd1) begin
            tests_failed++;
            $display("[TB] FAIL fill_src_ignored: got cyc=%0d found=%0d err=%0d words=%0d, expected 3 1 0 1",
                     dcyc, found, derr, dwords);
        end
        @(negedge CLK);
        tests_run++;
        if (mem[32] !== 32'h0BAD_F00D) begin
            tests_failed++;
            $display("[TB] FAIL fill_src_ignored_mem: got %h, expected 0badf00d", mem[32]);
        end
    endtask

    task automatic test_abort();
        bit found, derr, dab, dbusy; int dcyc; logic [LenWidth-1:0] dwords;
        for (int i = 0; i < 6; i++) preload(192 + i, 32'hC0DE_0000 + 32'(i));
        preload(229, 32'h5A5A_5A5A);
        do_start(1'b0, 32'h300, 32'h380, 16'd16, 32'h0);
        repeat (4) @(negedge CLK);
        abort_i = 1'b1;
        @(negedge CLK);
        abort_i = 1'b0;
        wait_done(40, found, dcyc, derr, dab, dwords, dbusy);
        tests_run++;
        if (!found || dcyc != 9 || !dab || derr || dwords !== 16'd5) begin
            tests_failed++;
            $display("[TB] FAIL abort_done: got cyc=%0d found=%0d ab=%0d err=%0d words=%0d, expected 9 1 1 0 5",
                     dcyc, found, dab, derr, dwords);
        end
        tests_run++;
        if (rd_log_addr.size() - rd_base != 5 || wr_log_addr.size() - wr_base != 5) begin
            tests_failed++;
            $display("[TB] FAIL abort_req_count: got rd=%0d wr=%0d, expected 5 5",
                     rd_log_addr.size() - rd_base, wr_log_addr.size() - wr_base);
        end
        @(negedge CLK);
        tests_run++;
        if (mem[224] !== 32'hC0DE_0000 || mem[228] !== 32'hC0DE_0004 || mem[229] !== 32'h5A5A_5A5A) begin
            tests_failed++;
            $display("[TB] FAIL abort_mem: got %h %h %h, expected c0de0000 c0de0004 5a5a5a5a",
                     mem[224], mem[228], mem[229]);
        end
    endtask

    task automatic test_start_busy();
        bit found, derr, dab, dbusy; int dcyc; logic [LenWidth-1:0] dwords;
        int done_before;
        done_before = done_count;
        do_start(1'b0, 32'h0, 32'h140, 16'd4, 32'h0);
        repeat (2) @(negedge CLK);
        mode_i     = 1'b1;
        src_addr_i = 32'h10;
        dst_addr_i = 32'h1C0;
        len_i      = 16'd2;
        start_i    = 1'b1;
        @(negedge CLK);
        start_i    = 1'b0;
        wait_done(40, found, dcyc, derr, dab, dwords, dbusy);
        tests_run++;
        if (!found || dcyc != 8 || dwords !== 16'd4 || derr || dab) begin
            tests_failed++;
            $display("[TB] FAIL busy_start_done: got cyc=%0d found=%0d words=%0d err=%0d ab=%0d, expected 8 1 4 0 0",
                     dcyc, found, dwords, derr, dab);
        end
        repeat (6) @(negedge CLK);
        tests_run++;
        if (rd_log_addr.size() - rd_base != 4 || wr_log_addr.size() - wr_base != 4
            || done_count - done_before != 1) begin
            tests_failed++;
            $display("[TB] FAIL busy_start_reqs: got rd=%0d wr=%0d dones=%0d, expected 4 4 1",
                     rd_log_addr.size() - rd_base, wr_log_addr.size() - wr_base, done_count - done_before);
        end
        tests_run++;
        if (mem[80] !== 32'h1111_00A0 || mem[83] !== 32'h4444_00A3) begin
            tests_failed++;
            $display("[TB] FAIL busy_start_mem: got %h %h, expected 111100a0 444400a3", mem[80], mem[83]);
        end
    endtask

    task automatic test_reset_mid();
        bit found, derr, dab, dbusy; int dcyc; logic [LenWidth-1:0] dwords;
        int done_before;
        do_start(1'b0, 32'h0, 32'h180, 16'd4, 32'h0);
        repeat (3) @(negedge CLK);
        tests_run++;
        if (wr_req_o !== 1'b1 || wr_addr_o !== 32'h184) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_second_write: got req=%b addr=%h, expected 1 00000184", wr_req_o, wr_addr_o);
        end
        done_before = done_count;
        RST_N = 1'b0;
        #1;
        tests_run++;
        if ({busy_o, done_o, rd_req_o, wr_req_o, wr_we_o} !== 5'b0 || wr_be_o !== 4'h0 || words_o !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_outputs: got flags=%b be=%h words=%0d, expected 00000 0 0",
                     {busy_o, done_o, rd_req_o, wr_req_o, wr_we_o}, wr_be_o, words_o);
        end
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        repeat (10) @(negedge CLK);
        tests_run++;
        if (done_count != done_before || busy_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_no_done: got dones=%0d busy=%b, expected 0 0",
                     done_count - done_before, busy_o);
        end
        do_start(1'b0, 32'h0, 32'h1C0, 16'd4, 32'h0);
        wait_done(40, found, dcyc, derr, dab, dwords, dbusy);
        tests_run++;
        if (!found || dcyc != 8 || dwords !== 16'd4 || derr || dab) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_fresh: got cyc=%0d found=%0d words=%0d err=%0d ab=%0d, expected 8 1 4 0 0",
                     dcyc, found, dwords, derr, dab);
        end
        @(negedge CLK);
        tests_run++;
        if (mem[112] !== 32'h1111_00A0 || mem[115] !== 32'h4444_00A3) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_mem: got %h %h, expected 111100a0 444400a3", mem[112], mem[115]);
        end
    endtask

    initial begin
        RST_N      = 1'b0;
        start_i    = 1'b0;
        mode_i     = 1'b0;
        src_addr_i = '0;
        dst_addr_i = '0;
        len_i      = '0;
        pattern_i  = '0;
        abort_i    = 1'b0;
        test_reset();
        test_copy();
        test_fill();
        test_errors();
        test_abort();
        test_start_busy();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
